io_stall_injector: RTL and testbench

//  Sits on the Host->Logic GLIP FIFO path between glip_cypressfx3_toplevel and io_stress_test.

---
 rtl/io_stress_pkg.sv | 22 ++
 rtl/io_stall_lfsr.sv | 22 ++
 rtl/io_stall_injector.sv | 126 ++++++++++++
 tb/tb_io_stall_injector.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_stress_pkg.sv
// Shared constants and helpers for the GLIP I/O stress path: LFSR taps, default seed,
// counter width and a saturating increment.
`timescale 1ns/1ps
package io_stress_pkg;

   // Galois mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
   localparam logic [15:0] LFSR_TAPS     = 16'hB400;
   localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
   localparam int          CNT_WIDTH_DEF = 32;
   localparam int          SAT_MAX_W     = 64;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

   // Counters up to 64 bits wide share this; callers pass their own all-ones limit.
   function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] value,
                                                    input logic [SAT_MAX_W-1:0] max_val);
      return (value >= max_val) ? value : value + SAT_MAX_W'(1);
   endfunction

endpackage

// File: rtl/io_stall_lfsr.sv
// 16-bit Galois LFSR that steps once per cycle while advance is high.
`timescale 1ns/1ps
module io_stall_lfsr
   import io_stress_pkg::*;
#(
   parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        advance,
   output logic [15:0] state
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SEED;
      end else if (advance) begin
         state <= lfsr_step(state);
      end
   end

endmodule

// File: rtl/io_stall_injector.sv
// Two-entry FIFO on the Host->Logic GLIP path that injects pseudo-random upstream
// backpressure and downstream bubbles, and counts words and blocking stall cycles.
`timescale 1ns/1ps
module io_stall_injector
   import io_stress_pkg::*;
#(
   parameter int          WIDTH     = 16,
   parameter logic [15:0] SEED      = LFSR_SEED_DEF,
   parameter int          CNT_WIDTH = CNT_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [3:0]           stall_rate,
   input  logic                 clear_cnt,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CNT_WIDTH-1:0] word_count,
   output logic [CNT_WIDTH-1:0] stall_count
);

   localparam logic [SAT_MAX_W-1:0] CNT_MAX = SAT_MAX_W'({CNT_WIDTH{1'b1}});

   logic [15:0]      lfsr;
   logic [1:0]       count;
   logic [1:0]       count_nxt;
   logic             hold;
   logic [WIDTH-1:0] slot0;
   logic [WIDTH-1:0] slot1;
   logic [WIDTH-1:0] slot0_nxt;
   logic [WIDTH-1:0] slot1_nxt;
   logic             stall_in;
   logic             stall_out;
   logic             not_full;
   logic             not_empty;
   logic             push;
   logic             pop;
   logic             stall_event;

   io_stall_lfsr #(.SEED(SEED)) u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (enable),
      .state   (lfsr)
   );

   assign stall_in  = enable & (lfsr[3:0] < stall_rate);
   assign stall_out = enable & (lfsr[7:4] < stall_rate);
   assign not_full  = (count != 2'd2);
   assign not_empty = (count != 2'd0);

   // Handshake: a word moves when valid & ready are both high at a rising edge.
   // in_ready may drop at any time; out_valid, once high, stays high with stable
   // out_data until accepted (hold bypasses stall_out).
   assign in_ready  = rst_n & not_full & ~stall_in;
   assign out_valid = rst_n & not_empty & (hold | ~stall_out);
   assign out_data  = slot0;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   assign stall_event = (in_valid & not_full & stall_in) | (not_empty & ~hold & stall_out);

   // slot0 is always the head; slot1 holds the second word when count is 2.
   always_comb begin
      slot0_nxt = slot0;
      slot1_nxt = slot1;
      count_nxt = count;
      case ({push, pop})
         2'b10: begin
            if (count == 2'd0) begin
               slot0_nxt = in_data;
            end else begin
               slot1_nxt = in_data;
            end
            count_nxt = count + 2'd1;
         end
         2'b01: begin
            slot0_nxt = slot1;
            count_nxt = count - 2'd1;
         end
         2'b11: begin
            if (count == 2'd1) begin
               slot0_nxt = in_data;
            end else begin
               slot0_nxt = slot1;
               slot1_nxt = in_data;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count       <= 2'd0;
         hold        <= 1'b0;
         slot0       <= '0;
         slot1       <= '0;
         word_count  <= '0;
         stall_count <= '0;
      end else begin
         count <= count_nxt;
         slot0 <= slot0_nxt;
         slot1 <= slot1_nxt;
         hold  <= out_valid & ~out_ready;
         if (clear_cnt) begin
            word_count  <= '0;
            stall_count <= '0;
         end else begin
            if (pop) begin
               word_count <= CNT_WIDTH'(sat_inc(SAT_MAX_W'(word_count), CNT_MAX));
            end
            if (stall_event) begin
               stall_count <= CNT_WIDTH'(sat_inc(SAT_MAX_W'(stall_count), CNT_MAX));
            end
         end
      end
   end

endmodule

// File: tb/tb_io_stall_injector.sv
// Directed bench for io_stall_injector: vector table, streaming scoreboard, and
// hand-written sequences for backpressure, hold, saturation and reset.
`timescale 1ns/1ps
module tb_io_stall_injector;

   localparam int          WIDTH = 16;
   localparam int          CW    = 32;
   localparam int          SW    = 4;
   localparam logic [15:0] SEED  = 16'hACE1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            enable = 1'b0;
   logic [3:0]      stall_rate = 4'd0;
   logic            clear_cnt = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [WIDTH-1:0] out_data;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [CW-1:0]   word_count;
   logic [CW-1:0]   stall_count;

   logic            s_enable = 1'b0;
   logic [3:0]      s_stall_rate = 4'd0;
   logic            s_clear_cnt = 1'b0;
   logic [WIDTH-1:0] s_in_data = 16'h5A5A;
   logic            s_in_valid = 1'b0;
   logic            s_in_ready;
   logic [WIDTH-1:0] s_out_data;
   logic            s_out_valid;
   logic            s_out_ready = 1'b0;
   logic [SW-1:0]   s_word_count;
   logic [SW-1:0]   s_stall_count;

   int n_checks = 0;
   int n_fail   = 0;
   logic [WIDTH-1:0] exp_q[$];

   typedef struct {
      logic             iv;
      logic [WIDTH-1:0] id;
      logic             ordy;
      logic             e_irdy;
      logic             e_ov;
      logic             chk_d;
      logic [WIDTH-1:0] e_od;
   } vec_t;

   vec_t tbl[11];

   io_stall_injector #(.WIDTH(WIDTH), .SEED(SEED), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .stall_rate(stall_rate),
      .clear_cnt(clear_cnt), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .word_count(word_count), .stall_count(stall_count)
   );

   io_stall_injector #(.WIDTH(WIDTH), .SEED(SEED), .CNT_WIDTH(SW)) dut_small (
      .clk(clk), .rst_n(rst_n), .enable(s_enable), .stall_rate(s_stall_rate),
      .clear_cnt(s_clear_cnt), .in_data(s_in_data), .in_valid(s_in_valid),
      .in_ready(s_in_ready), .out_data(s_out_data), .out_valid(s_out_valid),
      .out_ready(s_out_ready), .word_count(s_word_count), .stall_count(s_stall_count)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference LFSR: x^16+x^14+x^13+x^11+1, shifted right, taps folded in on a 1 out.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      logic [15:0] r;
      r = {1'b0, s[15:1]};
      if (s[0]) r = r ^ 16'hB400;
      return r;
   endfunction

   logic [15:0] m_lfsr;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)      m_lfsr <= SEED;
      else if (enable) m_lfsr <= lfsr_next(m_lfsr);
   end

   // ---------------- check / driver tasks ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      clear_cnt   = 1'b0;
      s_in_valid  = 1'b0;
      s_out_ready = 1'b0;
      s_clear_cnt = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_word_count", word_count, 0);
      check("rst_stall_count", stall_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic small_pops(input int n, input string name);
      int got = 0;
      for (int c = 0; c < 4 * n + 8 && got < n; c++) begin
         @(negedge clk);
         if (s_out_valid && s_out_ready) got++;
         tick();
      end
      check(name, got, n);
   endtask

   // ---------------- scoreboard ----------------
   logic             prev_hold = 1'b0;
   logic [WIDTH-1:0] prev_data = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            check("no_retract_valid", out_valid, 1);
            check("no_retract_data", out_data, prev_data);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_unexpected_word: got %0h expected no word at %0t", out_data, $time);
            end else begin
               check("sb_data", out_data, exp_q.pop_front());
            end
         end
         if (in_valid && in_ready) exp_q.push_back(in_data);
         prev_hold = out_valid & ~out_ready;
         prev_data = out_data;
      end
   end

   // ---------------- test sequence ----------------
   initial begin
      int          cycles;
      bit          timeout;
      bit          held;
      int          forced;
      int          exp_stalls;
      logic        so;
      logic        run1[20];
      logic [15:0] lf;

      //            iv    id        ordy  e_irdy e_ov chk_d e_od
      tbl[0]  = '{1'b1, 16'h00A1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000};
      tbl[1]  = '{1'b1, 16'h00A2, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00A1};
      tbl[2]  = '{1'b1, 16'h00A3, 1'b0, 1'b0, 1'b1, 1'b1, 16'h00A1};
      tbl[3]  = '{1'b1, 16'h00A3, 1'b1, 1'b0, 1'b1, 1'b1, 16'h00A1};
      tbl[4]  = '{1'b1, 16'h00A3, 1'b1, 1'b1, 1'b1, 1'b1, 16'h00A2};
      tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h00A3};
      tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
      tbl[7]  = '{1'b1, 16'h00B1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
      tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00B1};
      tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h00B1};
      tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};

      // Vector table, clean pass-through.
      do_reset();
      for (int i = 0; i < 11; i++) begin
         in_valid  = tbl[i].iv;
         in_data   = tbl[i].id;
         out_ready = tbl[i].ordy;
         @(negedge clk);
         check("tbl_in_ready", in_ready, tbl[i].e_irdy);
         check("tbl_out_valid", out_valid, tbl[i].e_ov);
         if (tbl[i].chk_d) check("tbl_out_data", out_data, tbl[i].e_od);
         tick();
      end
      check("tbl_word_count", word_count, 4);
      check("tbl_stall_count", stall_count, 0);

      // 100 back-to-back words, enable=0.
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         in_valid = 1'b1;
         in_data  = 16'(i);
         @(negedge clk);
         check("t1_in_ready", in_ready, 1);
         if (i > 0) begin
            check("t1_out_valid", out_valid, 1);
            check("t1_latency_data", out_data, 64'(i - 1));
         end
         tick();
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("t1_last_valid", out_valid, 1);
      check("t1_last_data", out_data, 99);
      tick();
      @(negedge clk);
      check("t1_empty", out_valid, 0);
      check("t1_word_count", word_count, 100);
      check("t1_stall_count", stall_count, 0);
      tick();

      // 1000 words under maximum stall rate with random downstream ready.
      do_reset();
      enable     = 1'b1;
      stall_rate = 4'd15;
      cycles     = 0;
      timeout    = 1'b0;
      for (int i = 0; i < 1000 && !timeout; i++) begin
         bit acc;
         acc      = 1'b0;
         in_valid = 1'b1;
         in_data  = 16'(i);
         while (!acc && !timeout) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_ready;
            tick();
            cycles++;
            if (cycles > 60000) timeout = 1'b1;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 2000 && exp_q.size() != 0; k++) tick();
      check("t2_timeout", timeout, 0);
      check("t2_drained", exp_q.size(), 0);
      check("t2_word_count", word_count, 1000);
      check("t2_stall_nonzero", stall_count != 0, 1);
      enable = 1'b0;

      // Downstream blocked while three words are offered.
      do_reset();
      in_valid = 1'b1;
      in_data  = 16'h00C0;
      @(negedge clk);
      check("t3_a_ready", in_ready, 1);
      check("t3_a_valid", out_valid, 0);
      tick();
      in_data = 16'h00C1;
      @(negedge clk);
      check("t3_b_ready", in_ready, 1);
      check("t3_b_valid", out_valid, 1);
      check("t3_b_data", out_data, 16'h00C0);
      tick();
      in_data = 16'h00C2;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t3_full_ready", in_ready, 0);
         check("t3_full_valid", out_valid, 1);
         check("t3_full_data", out_data, 16'h00C0);
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("t3_g_ready", in_ready, 0);
      check("t3_g_data", out_data, 16'h00C0);
      tick();
      @(negedge clk);
      check("t3_h_ready", in_ready, 1);
      check("t3_h_data", out_data, 16'h00C1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("t3_i_valid", out_valid, 1);
      check("t3_i_data", out_data, 16'h00C2);
      tick();
      @(negedge clk);
      check("t3_j_valid", out_valid, 0);
      tick();

      // Stall_out active while hold is set must not retract the word.
      do_reset();
      in_valid = 1'b1;
      in_data  = 16'hD00D;
      tick();
      in_valid   = 1'b0;
      enable     = 1'b1;
      stall_rate = 4'd15;
      held       = 1'b0;
      forced     = 0;
      exp_stalls = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         so = (m_lfsr[7:4] < stall_rate);
         if (!held) begin
            check("t4_ov_vs_lfsr", out_valid, 64'(!so));
            if (so) exp_stalls++;
         end else begin
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_data", out_data, 16'hD00D);
            if (so) forced++;
         end
         if (out_valid) held = 1'b1;
         tick();
      end
      check("t4_held", held, 1);
      check("t4_forced_stall_seen", forced > 0, 1);
      check("t4_stall_count", stall_count, 64'(exp_stalls));
      enable = 1'b0;
      @(negedge clk);
      check("t4_disable_ready", in_ready, 1);
      check("t4_disable_valid", out_valid, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Saturation and clear priority on a 4-bit counter instance.
      do_reset();
      s_in_valid  = 1'b1;
      s_out_ready = 1'b1;
      small_pops(14, "t5_pops_a");
      check("t5_count_14", s_word_count, 14);
      small_pops(3, "t5_pops_b");
      check("t5_saturated", s_word_count, 15);
      s_clear_cnt = 1'b1;
      @(negedge clk);
      check("t5_clear_pop_valid", s_out_valid, 1);
      tick();
      s_clear_cnt = 1'b0;
      check("t5_cleared", s_word_count, 0);
      s_in_valid  = 1'b0;

      // Reset while full, then identical stall sequence after each release.
      do_reset();
      in_valid = 1'b1;
      in_data  = 16'h00E0;
      tick();
      in_data = 16'h00E1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("t6_full", in_ready, 0);
      tick();
      enable     = 1'b1;
      stall_rate = 4'd8;
      for (int r = 0; r < 2; r++) begin
         #3;
         rst_n = 1'b0;
         #1;
         check("t6_rst_ready", in_ready, 0);
         check("t6_rst_valid", out_valid, 0);
         check("t6_rst_data", out_data, 0);
         @(negedge clk);
         @(negedge clk);
         rst_n = 1'b1;
         lf = SEED;
         for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            else #1;
            if (r == 0) run1[k] = in_ready;
            else check("t6_repeat", in_ready, run1[k]);
            check("t6_ready_vs_lfsr", in_ready, 64'(!(lf[3:0] < 4'd8)));
            if (k == 0) check("t6_k0", in_ready, 0);
            if (k == 1) check("t6_k1", in_ready, 0);
            if (k == 2) check("t6_k2", in_ready, 1);
            lf = lfsr_next(lf);
         end
         check("t6_no_stall_count", stall_count, 0);
         check("t6_empty", out_valid, 0);
         tick();
      end
      enable = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
